duet_orbit: RTL and testbench
=============================

DUET_ORBIT -- requirements
Module: duet_orbit

Interface
REQ-001 SHALL have parameter CENTER_X, default 320, orbit centre X in pixels.
REQ-002 SHALL have parameter CENTER_Y, default 400, orbit centre Y in pixels.
REQ-003 SHALL have parameter BALL_RADIUS, default 6, constant ball size output.
REQ-004 SHALL have port Clk  input  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-005 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port frame_clk  input  1  VGA vertical sync, asynchronous to Clk.
REQ-007 SHALL have port keycode  input  8  USB HID keycode of the held key; 0x00 means none.
REQ-008 SHALL have port pause  input  1  freeze rotation while high.
REQ-009 SHALL have port BallX  output  10 x [0:1]  ball X; index 0 blue, index 1 red.
REQ-010 SHALL have port BallY  output  10 x [0:1]  ball Y; same indexing.
REQ-011 SHALL have port Ball_size  output  10 x [0:1]  both entries BALL_RADIUS.
REQ-012 SHALL have port angle  output  6  current orbit angle, 64 steps per turn (5.625 deg).
REQ-013 SHALL have port pos_valid  output  1  one-cycle pulse when new positions are written.

Function
REQ-014 SHALL synchronise frame_clk through 2 flops; frame_tick = one-cycle pulse on synchronised rising edge.
REQ-015 SHALL run FSM IDLE -> STEP -> LOOKUP -> WRITE -> IDLE; leaves IDLE only when frame_tick is high.
REQ-016 SHALL ignore frame_tick when not in IDLE.
REQ-017 In STEP: key A (0x04) alone -> angle+1; key D (0x07) alone -> angle-1; otherwise angle holds.
REQ-018 SHALL hold angle in STEP when pause=1; FSM still completes and pos_valid still pulses.
REQ-019 SHALL wrap angle modulo 64: 63+1 -> 0, 0-1 -> 63.
REQ-020 In LOOKUP: register s = sin(angle), c = sin(angle+16) via 17-entry quarter-wave ROM with quadrant sign/mirror logic.
REQ-021 Quarter-wave ROM k=0..16 SHALL hold: 0,6,12,17,23,28,33,38,42,46,50,53,55,57,59,60,60.
REQ-022 In WRITE: BallX[0] = CENTER_X + c, BallY[0] = CENTER_Y - s, BallX[1] = CENTER_X - c, BallY[1] = CENTER_Y + s.
REQ-023 SHALL compute with signed 11-bit intermediates and truncate results to 10 bits.
REQ-024 SHALL drive pos_valid high for exactly one cycle: the cycle after WRITE.
REQ-025 Latency: tick in cycle T -> new outputs and pos_valid visible in cycle T+4.
REQ-026 Outputs SHALL be registered and stable between WRITE states.

Reset
REQ-027 Reset SHALL be sampled on Clk only and override all other activity, including mid-FSM.
REQ-028 On reset: angle=0, FSM=IDLE, sync flops=0, pos_valid=0.
REQ-029 On reset: BallX=(380,260), BallY=(400,400), Ball_size=(6,6).
REQ-030 A tick aborted by reset SHALL NOT produce a later WRITE.

Configuration
REQ-031 With macro DUET_ARROW_KEYS_EN defined: Left arrow (0x50) SHALL act as A and Right arrow (0x4F) as D.
REQ-032 Without DUET_ARROW_KEYS_EN: 0x50 and 0x4F SHALL be treated as no key.

Verification
REQ-033 Reset, release -> BallX=(380,260), BallY=(400,400), angle=0, pos_valid=0.
REQ-034 keycode=0x04 held for 16 ticks -> angle=16, BallX=(320,320), BallY=(340,460); pos_valid pulses 16 times, each at T+4.
REQ-035 From angle 0, keycode=0x07 for 1 tick -> angle=63, BallX=(380,260), BallY=(406,394).
REQ-036 keycode=0x00, 0x04 with pause=1, and an unmapped code each for 3 ticks -> angle stays 0, pos_valid pulses 3 times per case.
REQ-037 Reset asserted in LOOKUP cycle after an A tick -> angle=0, no pos_valid, outputs at reset values.
REQ-038 keycode=0x50 for 1 tick -> angle=1 with DUET_ARROW_KEYS_EN; angle=0 without it.

Source files
------------

// File: rtl/duet_orbit.sv
// Two-ball orbit position generator: steps a 64-position angle once per VGA frame
// and places the blue/red balls diametrically opposite on a fixed circle.
// Optional build macro DUET_ARROW_KEYS_EN: Left/Right arrows alias the A/D keys.
module duet_orbit #(
    parameter int CENTER_X    = 320,
    parameter int CENTER_Y    = 400,
    parameter int BALL_RADIUS = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       pause,
    output logic [9:0] BallX     [0:1],
    output logic [9:0] BallY     [0:1],
    output logic [9:0] Ball_size [0:1],
    output logic [5:0] angle,
    output logic       pos_valid
);

    localparam logic signed [10:0] CX      = 11'(CENTER_X);
    localparam logic signed [10:0] CY      = 11'(CENTER_Y);
    // cos(0) from the quarter-wave table, so reset positions match angle 0
    localparam logic signed [10:0] C_RESET = 11'sd60;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        LOOKUP,
        WRITE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        sync_reg;
    logic              sync_prev_reg;
    logic              frame_tick;
    logic              step_en, lookup_en, write_en;
    logic              key_ccw, key_cw;
    logic [5:0]        angle_reg, angle_next;
    logic signed [10:0] s_reg, c_reg;
    logic signed [10:0] sin_val [0:1];
    logic              pos_valid_reg;

    function automatic logic [5:0] quarter_rom(input logic [4:0] k);
        logic [5:0] v;
        case (k)
            5'd0:    v = 6'd0;
            5'd1:    v = 6'd6;
            5'd2:    v = 6'd12;
            5'd3:    v = 6'd17;
            5'd4:    v = 6'd23;
            5'd5:    v = 6'd28;
            5'd6:    v = 6'd33;
            5'd7:    v = 6'd38;
            5'd8:    v = 6'd42;
            5'd9:    v = 6'd46;
            5'd10:   v = 6'd50;
            5'd11:   v = 6'd53;
            5'd12:   v = 6'd55;
            5'd13:   v = 6'd57;
            5'd14:   v = 6'd59;
            5'd15:   v = 6'd60;
            5'd16:   v = 6'd60;
            default: v = 6'd0;
        endcase
        return v;
    endfunction

    // Quadrant bit 4 mirrors the table index, bit 5 negates the result
    function automatic logic signed [10:0] sin_lookup(input logic [5:0] idx);
        logic [4:0]         addr;
        logic signed [10:0] mag;
        addr = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        mag  = {5'd0, quarter_rom(addr)};
        return idx[5] ? -mag : mag;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_reg      <= 2'b00;
            sync_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], frame_clk};
            sync_prev_reg <= sync_reg[1];
        end
    end

    assign frame_tick = sync_reg[1] & ~sync_prev_reg;

`ifdef DUET_ARROW_KEYS_EN
    assign key_ccw = (keycode == 8'h04) || (keycode == 8'h50);
    assign key_cw  = (keycode == 8'h07) || (keycode == 8'h4F);
`else
    assign key_ccw = (keycode == 8'h04);
    assign key_cw  = (keycode == 8'h07);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_en    = 1'b0;
        lookup_en  = 1'b0;
        write_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_tick) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                step_en    = 1'b1;
                state_next = LOOKUP;
            end
            LOOKUP: begin
                lookup_en  = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                write_en   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        angle_next = angle_reg;
        if (step_en && !pause) begin
            if (key_ccw) begin
                angle_next = angle_reg + 6'd1;
            end else if (key_cw) begin
                angle_next = angle_reg - 6'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            angle_reg <= 6'd0;
        end else begin
            angle_reg <= angle_next;
        end
    end

    // Lookup 0 yields sin(angle); lookup 1 is a quarter turn ahead, i.e. cos(angle)
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic [5:0] idx;
            assign idx         = angle_reg + 6'(gi * 16);
            assign sin_val[gi] = sin_lookup(idx);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_reg <= 11'sd0;
            c_reg <= C_RESET;
        end else if (lookup_en) begin
            s_reg <= sin_val[0];
            c_reg <= sin_val[1];
        end
    end

    // Ball 0 sits at (+c, -s) from centre; ball 1 mirrors it through the centre
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ball
            logic [9:0] x_reg, y_reg;
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    x_reg <= 10'((gi == 0) ? (CX + C_RESET) : (CX - C_RESET));
                    y_reg <= 10'(CY);
                end else if (write_en) begin
                    x_reg <= 10'((gi == 0) ? (CX + c_reg) : (CX - c_reg));
                    y_reg <= 10'((gi == 0) ? (CY - s_reg) : (CY + s_reg));
                end
            end
            assign BallX[gi]     = x_reg;
            assign BallY[gi]     = y_reg;
            assign Ball_size[gi] = 10'(BALL_RADIUS);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_valid_reg <= 1'b0;
        end else begin
            pos_valid_reg <= write_en;
        end
    end

    assign angle     = angle_reg;
    assign pos_valid = pos_valid_reg;

endmodule

// File: tb/tb_duet_orbit.sv
// Bench for duet_orbit: trigonometric reference model with a per-cycle compare
// process, plus literal expectations for the documented scenarios.
module tb_duet_orbit;

    localparam int CX = 320;
    localparam int CY = 400;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       pause;
    logic [9:0] BallX     [0:1];
    logic [9:0] BallY     [0:1];
    logic [9:0] Ball_size [0:1];
    logic [5:0] angle;
    logic       pos_valid;

    duet_orbit #(
        .CENTER_X   (CX),
        .CENTER_Y   (CY),
        .BALL_RADIUS(6)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .keycode  (keycode),
        .pause    (pause),
        .BallX    (BallX),
        .BallY    (BallY),
        .Ball_size(Ball_size),
        .angle    (angle),
        .pos_valid(pos_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int due;
        int ang;
        int x0;
        int x1;
        int y0;
        int y1;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    int   cyc = 0;
    int   m_ang = 0;
    int   pulse_cnt = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   skip = 1'b1;
    bit   exp_v;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // 60*sin rounded to the nearest integer reproduces the quarter-wave table
    function automatic int msin(input int a);
        real r;
        r = 60.0 * $sin(2.0 * 3.14159265358979 * a / 64.0);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    function automatic int key_dir(input logic [7:0] kc);
        if (kc == 8'h04) return 1;
        if (kc == 8'h07) return -1;
`ifdef DUET_ARROW_KEYS_EN
        if (kc == 8'h50) return 1;
        if (kc == 8'h4F) return -1;
`endif
        return 0;
    endfunction

    function automatic rec_t make_rec(input int a, input int due);
        rec_t r;
        int   s, c;
        s     = msin(a);
        c     = msin((a + 16) % 64);
        r.due = due;
        r.ang = a;
        r.x0  = (CX + c) & 1023;
        r.x1  = (CX - c) & 1023;
        r.y0  = (CY - s) & 1023;
        r.y1  = (CY + s) & 1023;
        return r;
    endfunction

    always @(negedge Clk) begin
        if (!skip) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("pos_valid", int'(pos_valid), int'(exp_v));
            if (exp_v) begin
                cur = exp_q.pop_front();
                pulse_cnt++;
                $display("tick done: cycle %0d angle %0d X=(%0d,%0d) Y=(%0d,%0d)",
                         cyc, angle, BallX[0], BallX[1], BallY[0], BallY[1]);
            end
            chk("ballx0", int'(BallX[0]), cur.x0);
            chk("ballx1", int'(BallX[1]), cur.x1);
            chk("bally0", int'(BallY[0]), cur.y0);
            chk("bally1", int'(BallY[1]), cur.y1);
            chk("size0", int'(Ball_size[0]), 6);
            chk("size1", int'(Ball_size[1]), 6);
            if (exp_q.size() == 0) chk("angle", int'(angle), cur.ang);
        end
    end

    task automatic do_reset();
        skip  = 1'b1;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset     = 1'b0;
        exp_q.delete();
        m_ang     = 0;
        cur       = make_rec(0, 0);
        pulse_cnt = 0;
        skip      = 1'b0;
    endtask

    task automatic do_tick(input logic [7:0] kc, input logic p);
        rec_t r;
        #1;
        keycode = kc;
        pause   = p;
        @(posedge Clk);
        #1;
        frame_clk = 1'b1;
        if (!p) m_ang = (m_ang + key_dir(kc) + 64) % 64;
        // tick reaches the FSM 2 edges later, results 4 cycles after that
        r = make_rec(m_ang, cyc + 6);
        exp_q.push_back(r);
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (7) @(posedge Clk);
    endtask

    task automatic lit_pos(input string tag, input int x0, input int x1, input int y0, input int y1, input int a);
        @(negedge Clk);
        chk({tag, "_x0"}, int'(BallX[0]), x0);
        chk({tag, "_x1"}, int'(BallX[1]), x1);
        chk({tag, "_y0"}, int'(BallY[0]), y0);
        chk({tag, "_y1"}, int'(BallY[1]), y1);
        chk({tag, "_angle"}, int'(angle), a);
    endtask

    initial begin
        int exp_arrow;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        pause     = 1'b0;
        cur       = make_rec(0, 0);
        repeat (2) @(posedge Clk);
        do_reset();

        lit_pos("reset", 380, 260, 400, 400, 0);
        chk("reset_pos_valid", int'(pos_valid), 0);
        chk("reset_size0", int'(Ball_size[0]), 6);

        for (int i = 0; i < 16; i++) do_tick(8'h04, 1'b0);
        lit_pos("a16", 320, 320, 340, 460, 16);
        chk("a16_pulses", pulse_cnt, 16);

        do_reset();
        do_tick(8'h07, 1'b0);
        lit_pos("d1", 380, 260, 406, 394, 63);
        do_tick(8'h04, 1'b0);
        lit_pos("wrap_up", 380, 260, 400, 400, 0);

        do_reset();
        for (int i = 0; i < 3; i++) do_tick(8'h00, 1'b0);
        chk("none_pulses", pulse_cnt, 3);
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) do_tick(8'h04, 1'b1);
        chk("pause_pulses", pulse_cnt, 3);
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) do_tick(8'h2A, 1'b0);
        chk("unmapped_pulses", pulse_cnt, 3);
        lit_pos("hold", 380, 260, 400, 400, 0);

        for (int i = 0; i < 5; i++) do_tick(8'h07, 1'b0);
        do_tick(8'h07, 1'b1);
        for (int i = 0; i < 3; i++) do_tick(8'h04, 1'b0);
        chk("mixed_angle_model", m_ang, 62);

        // Reset lands on the LOOKUP cycle of an A tick: no write may follow
        do_reset();
        skip = 1'b1;
        #1;
        keycode = 8'h04;
        pause   = 1'b0;
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        cur       = make_rec(0, 0);
        pulse_cnt = 0;
        skip      = 1'b0;
        repeat (12) @(posedge Clk);
        lit_pos("abort", 380, 260, 400, 400, 0);
        chk("abort_pulses", pulse_cnt, 0);

`ifdef DUET_ARROW_KEYS_EN
        exp_arrow = 1;
`else
        exp_arrow = 0;
`endif
        do_reset();
        do_tick(8'h50, 1'b0);
        @(negedge Clk);
        chk("arrow_left_angle", int'(angle), exp_arrow);
        do_tick(8'h4F, 1'b0);
        @(negedge Clk);
        chk("arrow_right_angle", int'(angle), 0);

        repeat (4) @(posedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
